// File: rtl/deco_lectura_registros.sv
// ---------------------------------------------------------------------------
// deco_lectura_registros
//
// Read-side responder for the neural-network register map. Decodes bus read
// requests against the coefficient bank, offset, input, status and captured
// result registers. It returns registered data one cycle after the request.
// It also keeps sticky Done/Overrun flags and a held copy of the network result.
//
// Ports:
//   Clock      rising-edge system clock
//   ResetN     synchronous active-low reset
//   Address    byte address of the access (word aligned)
//   Read       read strobe, one request per cycle
//   Write      write strobe of the same bus; a read with Write=1 is ignored
//   Coeff      flattened coefficient registers, coeff k at [k*DATA_WIDTH +: DATA_WIDTH]
//   Offset     offset coefficient register
//   Entrada    input register
//   Salida     network result, valid only while Done is high
//   Done       single-cycle end-of-computation pulse
//   Busy       network computing, reported live in status bit 0
//   ReadData   registered read data
//   ReadValid  one-cycle response strobe
//   ReadError  response qualifier: unmapped address
//   DoneIrq    level copy of the sticky Done flag
// ---------------------------------------------------------------------------
module deco_lectura_registros #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_COEFF  = 20,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                            Clock,
    input  logic                            ResetN,
    input  logic [ADDR_WIDTH-1:0]           Address,
    input  logic                            Read,
    input  logic                            Write,
    input  logic [NUM_COEFF*DATA_WIDTH-1:0] Coeff,
    input  logic [DATA_WIDTH-1:0]           Offset,
    input  logic [DATA_WIDTH-1:0]           Entrada,
    input  logic [DATA_WIDTH-1:0]           Salida,
    input  logic                            Done,
    input  logic                            Busy,
    output logic [DATA_WIDTH-1:0]           ReadData,
    output logic                            ReadValid,
    output logic                            ReadError,
    output logic                            DoneIrq
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_OFFSET  = ADDR_WIDTH'('h150);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ENTRADA = ADDR_WIDTH'('h154);
    localparam logic [ADDR_WIDTH-1:0] ADDR_START   = ADDR_WIDTH'('h158);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS  = ADDR_WIDTH'('h15C);
    localparam logic [ADDR_WIDTH-1:0] ADDR_RESULT  = ADDR_WIDTH'('h160);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic                    accept;
    logic                    status_read;
    logic [DATA_WIDTH-1:0]   dec_data;
    logic                    dec_error;
    logic [DATA_WIDTH-1:0]   read_data;
    logic                    read_error;
    logic                    done_sticky;
    logic                    overrun;
    logic                    sticky_next;
    logic                    overrun_next;
    logic [DATA_WIDTH-1:0]   result_hold;

    // A read that collides with a write on the same bus is ignored entirely.
    assign accept      = Read & ~Write;
    assign status_read = accept & (Address == ADDR_STATUS);

    // Address decode. Every mapped address is word aligned, so any access
    // with Address[1:0] != 0 drops through to the error default.
    always_comb begin
        dec_data  = '0;
        dec_error = 1'b1;
        for (int k = 0; k < NUM_COEFF; k++) begin
            if (Address == ADDR_WIDTH'('h100 + 4 * k)) begin
                dec_data  = Coeff[k*DATA_WIDTH +: DATA_WIDTH];
                dec_error = 1'b0;
            end
        end
        case (Address)
            ADDR_OFFSET: begin
                dec_data  = Offset;
                dec_error = 1'b0;
            end
            ADDR_ENTRADA: begin
                dec_data  = Entrada;
                dec_error = 1'b0;
            end
            ADDR_START: begin
                dec_data  = '0;
                dec_error = 1'b0;
            end
            ADDR_STATUS: begin
                dec_data  = {{(DATA_WIDTH-3){1'b0}}, overrun, done_sticky, Busy};
                dec_error = 1'b0;
            end
            ADDR_RESULT: begin
                dec_data  = result_hold;
                dec_error = 1'b0;
            end
            default: ;
        endcase
    end

    // Response FSM: RESP lasts one cycle per accepted request and chains
    // directly into another RESP on back-to-back requests.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? RESP : IDLE;
            RESP:    next_state = accept ? RESP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Response data and error. Data holds between responses, while error
    // is forced low whenever there is no response.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            read_data  <= '0;
            read_error <= 1'b0;
        end else if (accept) begin
            read_data  <= dec_data;
            read_error <= dec_error;
        end else begin
            read_error <= 1'b0;
        end
    end

    // Sticky flags. A status read clears both flags. A coincident Done
    // overrides that clear for DoneSticky. Overrun then reflects only
    // whether DoneSticky was already set before this edge.
    always_comb begin
        sticky_next  = done_sticky;
        overrun_next = overrun;
        if (status_read) begin
            sticky_next  = 1'b0;
            overrun_next = 1'b0;
        end
        if (Done) begin
            sticky_next  = 1'b1;
            overrun_next = done_sticky | (overrun & ~status_read);
        end
    end

    // A result read on the Done edge sees the old value because the decode
    // uses result_hold before this update.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            done_sticky <= 1'b0;
            overrun     <= 1'b0;
            result_hold <= '0;
        end else begin
            done_sticky <= sticky_next;
            overrun     <= overrun_next;
            if (Done) begin
                result_hold <= Salida;
            end
        end
    end

    assign ReadData  = read_data;
    assign ReadError = read_error;
    assign ReadValid = (state == RESP);
    assign DoneIrq   = done_sticky;

endmodule
